// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_serializer_pkg
// Shared constants for the parallel-in/serial-out stage that feeds the "101"
// sequence detector.
//   state_t        : FSM state encoding (IDLE = 1'b0, SHIFT = 1'b1)
//   DEFAULT_WIDTH  : default word width, shared with the detector-level bench
// -----------------------------------------------------------------------------
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one
// bit per clock on Dout. A word accepted at edge k presents bit i on Dout during
// the cycle after edge k+i. A new word offered during the last-bit cycle is
// accepted at that edge, so back-to-back words stream without a gap.
//
// Parameters:
//   WIDTH     : word width in bits (>= 2)
//   MSB_FIRST : 1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first
//   IDLE_BIT  : value on Dout whenever Dout_valid = 0
//
// Ports:
//   Clk        in   system clock, rising edge
//   Rst        in   synchronous active-high reset
//   Load_valid in   Load_data holds a word to serialize
//   Load_ready out  block can accept a word this cycle (combinational)
//   Load_data  in   parallel word, sampled only on accept
//   Dout       out  serial bit stream (registered)
//   Dout_valid out  Dout carries a payload bit (registered)
//   Last       out  Dout carries the final bit of the word (registered)
//   Busy       out  a word is in flight (registered)
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load_valid,
  output logic             Load_ready,
  input  logic [WIDTH-1:0] Load_data,
  output logic             Dout,
  output logic             Dout_valid,
  output logic             Last,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             dout_n, dout_valid_n, last_n, busy_n;
  logic             accept;

  // Ready never looks at Load_valid, so there is no combinational loop through
  // an upstream stage whose valid depends on our ready.
  assign Load_ready = (state == IDLE) || (cnt == CNT_LAST);
  assign accept     = Load_valid && Load_ready;

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sreg_n       = sreg;
    dout_n       = Dout;
    dout_valid_n = Dout_valid;
    last_n       = Last;
    busy_n       = Busy;

    if (state == SHIFT && cnt != CNT_LAST) begin
      // Mid-word: the next bit comes from the head of the shift register.
      dout_n = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
      sreg_n = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
      cnt_n  = cnt + 1'b1;
      last_n = (cnt == CNT_PRE);
    end else if (accept) begin
      // Bit 0 goes straight to Dout at the accept edge; the register keeps
      // only the bits still to be sent.
      state_n      = SHIFT;
      cnt_n        = '0;
      dout_n       = MSB_FIRST ? Load_data[WIDTH-1] : Load_data[0];
      sreg_n       = MSB_FIRST ? (Load_data << 1) : (Load_data >> 1);
      dout_valid_n = 1'b1;
      last_n       = 1'b0;
      busy_n       = 1'b1;
    end else begin
      // Idle, or last bit done with nothing queued behind it.
      state_n      = IDLE;
      cnt_n        = '0;
      sreg_n       = '0;
      dout_n       = IDLE_BIT;
      dout_valid_n = 1'b0;
      last_n       = 1'b0;
      busy_n       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: the shift register is reset as well so a mid-word reset leaves
      // no stale payload behind; it is small, so this costs nothing notable.
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      Dout       <= IDLE_BIT;
      Dout_valid <= 1'b0;
      Last       <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sreg       <= sreg_n;
      Dout       <= dout_n;
      Dout_valid <= dout_valid_n;
      Last       <= last_n;
      Busy       <= busy_n;
    end
  end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Directed bench for piso_serializer. Instance u_dut uses the defaults
// (WIDTH 8, MSB first, idle bit 0); instance u_lsb uses WIDTH 4, LSB first,
// idle bit 1. Inputs are driven and outputs sampled 1 time unit after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;

  logic       lv = 1'b0;
  logic [7:0] ld = '0;
  logic       lr, dout, dv, last, busy;

  logic       lv4 = 1'b0;
  logic [3:0] ld4 = '0;
  logic       lr4, dout4, dv4, last4, busy4;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  piso_serializer u_dut (
    .Clk(Clk), .Rst(Rst),
    .Load_valid(lv), .Load_ready(lr), .Load_data(ld),
    .Dout(dout), .Dout_valid(dv), .Last(last), .Busy(busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .Clk(Clk), .Rst(Rst),
    .Load_valid(lv4), .Load_ready(lr4), .Load_data(ld4),
    .Dout(dout4), .Dout_valid(dv4), .Last(last4), .Busy(busy4)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Idle-state check of the default instance.
  task automatic expect_idle(input string tag);
    checks++;
    if ({dout, dv, last, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL %s idle outputs {dout,dv,last,busy} got %b exp 0000", tag, {dout, dv, last, busy});
    end
    checks++;
    if (lr !== 1'b1) begin
      errors++;
      $display("FAIL %s idle ready got %b exp 1", tag, lr);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; lv = 1'b1; ld = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({dout, dv, last, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset outputs cycle %0d got %b exp 0000", i, {dout, dv, last, busy});
      end
    end
    Rst = 1'b0; lv = 1'b0;
    checks++;
    if (dout4 !== 1'b1 || dv4 !== 1'b0) begin
      errors++;
      $display("FAIL reset lsb idle dout/dv got %b%b exp 10", dout4, dv4);
    end
    tick();
    expect_idle("reset_release");
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    lv = 1'b1; ld = w;
    tick();
    lv = 1'b0; ld = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout !== w[7-i] || dv !== 1'b1 || last !== (i == 7) || busy !== 1'b1) begin
        errors++;
        $display("FAIL single bit %0d {dout,dv,last,busy} got %b exp %b", i,
                 {dout, dv, last, busy}, {w[7-i], 1'b1, (i == 7), 1'b1});
      end
      checks++;
      if (lr !== (i == 7)) begin
        errors++;
        $display("FAIL single ready bit %0d got %b exp %b", i, lr, (i == 7));
      end
      tick();
    end
    expect_idle("single_after");
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    int lasts;
    w = 16'hA53C;
    lasts = 0;
    lv = 1'b1; ld = 8'hA5;
    checks++;
    if (lr !== 1'b1) begin
      errors++;
      $display("FAIL b2b idle ready got %b exp 1", lr);
    end
    tick();
    ld = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        lv = 1'b0; ld = 8'h00;
      end
      checks++;
      if (dout !== w[15-i] || dv !== 1'b1) begin
        errors++;
        $display("FAIL b2b bit %0d dout/dv got %b%b exp %b1", i, dout, dv, w[15-i]);
      end
      checks++;
      if (lr !== (i == 7 || i == 15)) begin
        errors++;
        $display("FAIL b2b ready bit %0d got %b exp %b", i, lr, (i == 7 || i == 15));
      end
      if (last === 1'b1) lasts++;
      tick();
    end
    checks++;
    if (lasts != 2) begin
      errors++;
      $display("FAIL b2b last pulses got %0d exp 2", lasts);
    end
    expect_idle("b2b_after");
  endtask

  task automatic test_load_while_busy();
    lv = 1'b1; ld = 8'hFF;
    tick();
    lv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        lv = 1'b1; ld = 8'h00;
      end
      if (i == 8) lv = 1'b0;
      checks++;
      if (dout !== (i < 8) || dv !== 1'b1 || last !== (i == 7 || i == 15)) begin
        errors++;
        $display("FAIL busy_load bit %0d {dout,dv,last} got %b exp %b", i,
                 {dout, dv, last}, {(i < 8), 1'b1, (i == 7 || i == 15)});
      end
      tick();
    end
    expect_idle("busy_load_after");
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    lv = 1'b1; ld = 8'hA5;
    tick();
    lv = 1'b0;
    tick(); tick(); tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    expect_idle("mid_reset");
    w = 8'h81;
    lv = 1'b1; ld = w;
    tick();
    lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout !== w[7-i] || dv !== 1'b1 || last !== (i == 7)) begin
        errors++;
        $display("FAIL mid_reset_next bit %0d {dout,dv,last} got %b exp %b", i,
                 {dout, dv, last}, {w[7-i], 1'b1, (i == 7)});
      end
      tick();
    end
    expect_idle("mid_reset_after");
  endtask

  task automatic test_lsb_first();
    logic [3:0] w;
    w = 4'b0001;
    checks++;
    if (dout4 !== 1'b1 || dv4 !== 1'b0 || lr4 !== 1'b1) begin
      errors++;
      $display("FAIL lsb idle {dout,dv,ready} got %b exp 101", {dout4, dv4, lr4});
    end
    lv4 = 1'b1; ld4 = w;
    tick();
    lv4 = 1'b0; ld4 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout4 !== w[i] || dv4 !== 1'b1 || last4 !== (i == 3) || busy4 !== 1'b1) begin
        errors++;
        $display("FAIL lsb bit %0d {dout,dv,last,busy} got %b exp %b", i,
                 {dout4, dv4, last4, busy4}, {w[i], 1'b1, (i == 3), 1'b1});
      end
      tick();
    end
    checks++;
    if ({dout4, dv4, last4, busy4} !== 4'b1000) begin
      errors++;
      $display("FAIL lsb after {dout,dv,last,busy} got %b exp 1000", {dout4, dv4, last4, busy4});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_load_while_busy();
    test_reset_mid_word();
    test_lsb_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_piso_serializer
